// File: rtl/if_fetch_queue_pkg.sv
// -----------------------------------------------------------------------------
// if_fetch_queue_pkg
// Shared types and constants for the instruction-fetch queue front end:
//   - fetch FSM state encoding
//   - default bus widths, instruction byte step and the all-zero instruction
// No ports (package).
// -----------------------------------------------------------------------------
package if_fetch_queue_pkg;

    // Default fetch address / instruction widths of the core.
    localparam int unsigned INST_ADDR_BUS_W = 64;
    localparam int unsigned INST_BUS_W      = 32;

    // Byte distance between consecutive instructions.
    localparam int unsigned INST_STEP_BYTES = 4;

    // Value presented on the decode data outputs when nothing is valid.
    localparam logic [INST_BUS_W-1:0] ZERO_INST = 32'h0000_0000;

    // Fetch FSM: IDLE = nothing in flight, WAIT = in flight and kept,
    // WAIT_DROP = in flight but its response will be thrown away.
    typedef enum logic [1:0] {
        FETCH_IDLE      = 2'b00,
        FETCH_WAIT      = 2'b01,
        FETCH_WAIT_DROP = 2'b10
    } fetch_state_e;

endpackage : if_fetch_queue_pkg

// File: rtl/if_fetch_queue_fifo.sv
// -----------------------------------------------------------------------------
// if_fetch_queue_fifo
// Synchronous DEPTH-entry FIFO holding fetched {pc, inst} entries.
// flush empties the FIFO and overrides push and pop in the same cycle.
// Ports:
//   clock    in   rising-edge clock
//   reset    in   asynchronous active-low reset
//   push_i   in   write data_i (ignored when full)
//   pop_i    in   drop head entry (ignored when empty)
//   flush_i  in   discard all entries
//   data_i   in   WIDTH-bit entry to write
//   data_o   out  WIDTH-bit head entry (meaningless when empty)
//   count_o  out  occupancy, 0..DEPTH
//   empty_o  out  occupancy == 0
//   full_o   out  occupancy == DEPTH
// -----------------------------------------------------------------------------
module if_fetch_queue_fifo #(
    parameter int unsigned WIDTH = 96,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    input  logic [WIDTH-1:0]           data_i,
    output logic [WIDTH-1:0]           data_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       empty_o,
    output logic                       full_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push_s;
    logic             do_pop_s;

    assign empty_o = (cnt_q == {CNT_W{1'b0}});
    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign count_o = cnt_q;
    assign data_o  = mem_q[rd_ptr_q];

    // Overflow/underflow requests are dropped so the pointers can never skew.
    assign do_push_s = push_i && !full_o;
    assign do_pop_s  = pop_i && !empty_o;

    // Next-state pointers and occupancy; flush wins over push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush_i) begin
            wr_ptr_d = {PTR_W{1'b0}};
            rd_ptr_d = {PTR_W{1'b0}};
            cnt_d    = {CNT_W{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   cnt_d = cnt_q + CNT_W'(1);
                2'b01:   cnt_d = cnt_q - CNT_W'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            cnt_q    <= {CNT_W{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Entry storage; contents only matter once the count says they are valid.
    always_ff @(posedge clock) begin
        if (do_push_s && !flush_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule : if_fetch_queue_fifo

// File: rtl/if_fetch_queue.sv
// -----------------------------------------------------------------------------
// if_fetch_queue
// Instruction-fetch front end: owns the fetch PC, issues one word request at a
// time to instruction memory (req/gnt/rvalid), buffers fetched {pc, inst}
// pairs in a DEPTH-entry queue and hands them to decode with valid/ready.
// A redirect flushes the queue and discards any response still in flight.
// Ports:
//   clock          in   rising-edge clock
//   reset          in   asynchronous active-low reset
//   redirect_i     in   taken branch/jump this cycle
//   redirect_pc_i  in   redirect target (bits [1:0] ignored)
//   imem_req_o     out  fetch request valid
//   imem_addr_o    out  fetch address (current fetch PC)
//   imem_gnt_i     in   memory accepts the request this cycle
//   imem_rvalid_i  in   response valid
//   imem_rdata_i   in   response instruction
//   id_valid_o     out  queue head valid
//   id_ready_i     in   decode accepts the head
//   id_pc_o        out  head PC (0 when not valid)
//   id_inst_o      out  head instruction (0 when not valid)
//   fq_count_o     out  queue occupancy
// -----------------------------------------------------------------------------
module if_fetch_queue
    import if_fetch_queue_pkg::*;
#(
    parameter int unsigned     ADDR_W   = INST_ADDR_BUS_W,
    parameter int unsigned     INST_W   = INST_BUS_W,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   redirect_i,
    input  logic [ADDR_W-1:0]      redirect_pc_i,
    output logic                   imem_req_o,
    output logic [ADDR_W-1:0]      imem_addr_o,
    input  logic                   imem_gnt_i,
    input  logic                   imem_rvalid_i,
    input  logic [INST_W-1:0]      imem_rdata_i,
    output logic                   id_valid_o,
    input  logic                   id_ready_i,
    output logic [ADDR_W-1:0]      id_pc_o,
    output logic [INST_W-1:0]      id_inst_o,
    output logic [$clog2(DEPTH):0] fq_count_o
);

    localparam int unsigned       ENTRY_W = ADDR_W + INST_W;
    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(INST_W / 8);

    fetch_state_e       state_q, state_d;
    logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0]  req_pc_q, req_pc_d;

    logic               grant_s;
    logic               push_s;
    logic               pop_s;
    logic               fifo_empty_s;
    logic               fifo_full_s;
    logic [ENTRY_W-1:0] head_s;

    // Credit check (not full) guarantees a granted response always has room.
    // Gated by reset so the request is low while reset is held.
    assign imem_req_o  = reset && (state_q == FETCH_IDLE) && !redirect_i && !fifo_full_s;
    assign imem_addr_o = fetch_pc_q;
    assign grant_s     = imem_req_o && imem_gnt_i;

    // Responses are kept only in WAIT, and never in a redirect cycle.
    assign push_s = (state_q == FETCH_WAIT) && imem_rvalid_i && !redirect_i;
    assign pop_s  = id_valid_o && id_ready_i && !redirect_i;

    assign id_valid_o = !fifo_empty_s;
    assign id_pc_o    = id_valid_o ? head_s[ENTRY_W-1:INST_W] : {ADDR_W{1'b0}};
    assign id_inst_o  = id_valid_o ? head_s[INST_W-1:0]       : ZERO_INST[INST_W-1:0];

    if_fetch_queue_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push_i  (push_s),
        .pop_i   (pop_s),
        .flush_i (redirect_i),
        .data_i  ({req_pc_q, imem_rdata_i}),
        .data_o  (head_s),
        .count_o (fq_count_o),
        .empty_o (fifo_empty_s),
        .full_o  (fifo_full_s)
    );

    // Fetch FSM next state; a redirect while waiting turns a pending response
    // into one to be dropped unless it arrives in the same cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH_IDLE: begin
                if (grant_s) begin
                    state_d = FETCH_WAIT;
                end else begin
                    state_d = FETCH_IDLE;
                end
            end
            FETCH_WAIT: begin
                if (imem_rvalid_i) begin
                    state_d = FETCH_IDLE;
                end else if (redirect_i) begin
                    state_d = FETCH_WAIT_DROP;
                end else begin
                    state_d = FETCH_WAIT;
                end
            end
            FETCH_WAIT_DROP: begin
                if (imem_rvalid_i) begin
                    state_d = FETCH_IDLE;
                end else begin
                    state_d = FETCH_WAIT_DROP;
                end
            end
            default: state_d = FETCH_IDLE;
        endcase
    end

    // Fetch PC and granted-address next state; redirect has priority.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        if (redirect_i) begin
            fetch_pc_d = {redirect_pc_i[ADDR_W-1:2], 2'b00};
        end else if (grant_s) begin
            fetch_pc_d = fetch_pc_q + PC_STEP;
        end else begin
            fetch_pc_d = fetch_pc_q;
        end
        if (grant_s) begin
            req_pc_d = fetch_pc_q;
        end else begin
            req_pc_d = req_pc_q;
        end
    end

    // State, fetch PC and granted-address registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= FETCH_IDLE;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= {ADDR_W{1'b0}};
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
        end
    end

endmodule : if_fetch_queue

// File: doc/if_fetch_queue.md
Name: if_fetch_queue

Overview:
Parametrised instruction-fetch front end, successor to the single-register IF stage. It owns the fetch PC and issues word requests to a variable-latency instruction memory over a req/gnt/rvalid handshake. Fetched {pc, inst} pairs are buffered in a DEPTH-entry queue and handed to decode with valid/ready. A branch redirect (PCSrc) flushes the queue and discards any in-flight response.

Parameters:
ADDR_W, 64, fetch/instruction address width (`InstAddrBus`)
INST_W, 32, instruction width (`InstBus`)
DEPTH, 4, queue entries; power of two, ≥2
RESET_PC, 0, fetch PC loaded on reset

Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low
redirect_i  in  1  PCSrc: taken branch/jump this cycle
redirect_pc_i  in  ADDR_W  redirect target; bits [1:0] ignored (treated as 0)
imem_req_o  out  1  fetch request valid
imem_addr_o  out  ADDR_W  fetch address (word aligned)
imem_gnt_i  in  1  memory accepts request this cycle
imem_rvalid_i  in  1  response valid
imem_rdata_i  in  INST_W  response instruction
id_valid_o  out  1  queue head valid to decode
id_ready_i  in  1  decode accepts head
id_pc_o  out  ADDR_W  PC of head instruction
id_inst_o  out  INST_W  head instruction
fq_count_o  out  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Interface: one clock; reset is asynchronous and active-low. Ports are named clock and reset.
- Reset (reset=0, immediate):
  - fetch_pc = RESET_PC; queue empty; FSM = IDLE.
  - All outputs 0: imem_req_o, id_valid_o, id_pc_o, id_inst_o, fq_count_o.
  - imem_addr_o = RESET_PC.
- At most one outstanding memory request.
- FSM states:
  - IDLE: no request in flight.
  - WAIT: one request in flight; its response will be kept.
  - WAIT_DROP: one request in flight; its response will be discarded.
- imem_req_o = (state==IDLE) && !redirect_i && (count < DEPTH). It is combinational, and imem_addr_o = fetch_pc.
- IDLE:
  - On req && gnt: fetch_pc += INST_W/8 (wraps mod 2^ADDR_W); go to WAIT.
  - A response with rvalid in IDLE is a protocol error and is ignored.
- WAIT, on rvalid:
  - Push {addr of that request, rdata}; go to IDLE.
  - A request can issue again the following cycle, so throughput is 1 instruction per 2 cycles minimum.
- WAIT_DROP, on rvalid: discard the response; go to IDLE.
- Redirect (highest priority, same cycle):
  - fetch_pc <= {redirect_pc_i[ADDR_W-1:2], 2'b00}.
  - Queue flushed; count = 0 next cycle.
  - No pop takes effect.
  - A response arriving in the redirect cycle is discarded.
  - If WAIT with no rvalid this cycle → WAIT_DROP. If WAIT with rvalid → IDLE. WAIT_DROP stays WAIT_DROP unless rvalid.
  - No new request is issued in the redirect cycle.
- Queue output:
  - id_valid_o = (count != 0).
  - id_pc_o/id_inst_o = head entry when valid, else 0.
  - Pop on id_valid_o && id_ready_i && !redirect_i.
- Simultaneous push and pop when full:
  - Not possible, because a request is only issued when count < DEPTH (credit).
  - Push and pop in the same cycle leaves count unchanged.
- Head data is stable while id_valid_o=1 and id_ready_i=0.
- The PC stored with each entry is the address that was granted, not the current fetch_pc.
- Pointers are log2(DEPTH) bits and wrap naturally; count is tracked separately.

Decomposition:
- defines.v additions:
  - `InstAddrBus`/`InstBus` widths.
  - Fetch FSM state encodings `FetchIdle`, `FetchWait`, `FetchWaitDrop`.
  - `ZeroInst`.
  - Instruction byte step (4).
- Sub-module fetch_fifo:
  - Parametrised synchronous FIFO (WIDTH=ADDR_W+INST_W, DEPTH).
  - Ports: push, pop, flush, data_in, data_out, count, empty, full.
  - Asynchronous active-low reset.
  - flush overrides push and pop.
- Top level holds fetch_pc, the FSM, a req_pc register (granted address), and glue logic.

Test Plan:
1. Reset release with RESET_PC=0, gnt=1 always, rvalid one cycle after gnt, id_ready=1 → imem_addr sequence 0,4,8,…; id_pc_o sequence 0,4,8 with matching rdata; fq_count never exceeds 1.
2. id_ready=0, memory always responding → 4 entries (PCs 0,4,8,C) fill; fq_count=4; imem_req_o=0 while full; raising id_ready drains in order and fetching resumes at 0x10.
3. Redirect to 0x1003 while in WAIT with response delayed 3 cycles → late response discarded; queue empty next cycle; next request addr=0x1000; first delivered id_pc_o=0x1000.
4. Redirect in the same cycle as rvalid and id_ready with queue holding 2 entries → neither push nor pop occurs; count=0; FSM=IDLE; next request at the redirect target.
5. Assert reset mid-WAIT with queue non-empty → outputs 0 immediately (asynchronous); after release, fetch restarts at RESET_PC; a stale rvalid in IDLE is ignored.
6. fetch_pc=0xFFFF_FFFF_FFFF_FFFC granted → next imem_addr_o=0 (wrap-around).
